// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: round-robin grant onto one shared downstream APB bus,
// each transfer held to completion, with an optional bounded pready wait.
module apb_arbiter #(
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32,
  parameter int P_STRB_W = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                pclk,
  input  logic                presetn,

  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [P_ADDR_W-1:0] m0_paddr,
  input  logic [P_DATA_W-1:0] m0_pwdata,
  input  logic [P_STRB_W-1:0] m0_pwstrb,
  output logic                m0_pready,
  output logic [P_DATA_W-1:0] m0_prdata,
  output logic                m0_pslverr,

  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [P_ADDR_W-1:0] m1_paddr,
  input  logic [P_DATA_W-1:0] m1_pwdata,
  input  logic [P_STRB_W-1:0] m1_pwstrb,
  output logic                m1_pready,
  output logic [P_DATA_W-1:0] m1_prdata,
  output logic                m1_pslverr,

  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [P_ADDR_W-1:0] s_paddr,
  output logic [P_DATA_W-1:0] s_pwdata,
  output logic [P_STRB_W-1:0] s_pwstrb,
  input  logic                s_pready,
  input  logic [P_DATA_W-1:0] s_prdata,
  input  logic                s_pslverr,

  output logic                timeout_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e                state_q,  state_d;
  logic                  grant_q,  grant_d;
  logic                  last_q,   last_d;
  logic                  pwrite_q, pwrite_d;
  logic [P_ADDR_W-1:0]   paddr_q,  paddr_d;
  logic [P_DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [P_STRB_W-1:0]   pwstrb_q, pwstrb_d;
  logic [P_DATA_W-1:0]   rdata_q,  rdata_d;
  logic                  err_q,    err_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  tpulse_q, tpulse_d;

  logic                  win;
  logic                  to_hit;
  logic                  unused_penable;

  // Upstream penable carries no arbitration information.
  assign unused_penable = m0_penable ^ m1_penable;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwstrb_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwstrb_q <= pwstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
    end
  end

  always_comb begin
    // Tie goes to the master that was not served last; otherwise the lone requester.
    win    = (m0_psel && m1_psel) ? ~last_q : (m1_psel && !m0_psel);
    to_hit = (TIMEOUT != 0) && !s_pready && (cnt_q == CNT_LAST);

    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwstrb_d = pwstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tpulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (m0_psel || m1_psel) begin
          grant_d  = win;
          last_d   = win;
          pwrite_d = win ? m1_pwrite : m0_pwrite;
          paddr_d  = win ? m1_paddr  : m0_paddr;
          pwdata_d = win ? m1_pwdata : m0_pwdata;
          pwstrb_d = win ? m1_pwstrb : m0_pwstrb;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (s_pready) begin
          rdata_d = s_prdata;
          err_d   = s_pslverr;
          state_d = S_DONE;
        end else if (to_hit) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          tpulse_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    s_psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    s_penable     = (state_q == S_ACCESS);
    s_pwrite      = pwrite_q;
    s_paddr       = paddr_q;
    s_pwdata      = pwdata_q;
    s_pwstrb      = pwstrb_q;
    m0_pready     = (state_q == S_DONE) && !grant_q;
    m1_pready     = (state_q == S_DONE) &&  grant_q;
    m0_pslverr    = m0_pready && err_q;
    m1_pslverr    = m1_pready && err_q;
    m0_prdata     = rdata_q;
    m1_prdata     = rdata_q;
    timeout_pulse = tpulse_q;
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration/slave model.
module tb_apb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic [AW-1:0] m0_paddr;
  logic [DW-1:0] m0_pwdata, m0_prdata;
  logic [SW-1:0] m0_pwstrb;
  logic          m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [AW-1:0] m1_paddr;
  logic [DW-1:0] m1_pwdata, m1_prdata;
  logic [SW-1:0] m1_pwstrb;
  logic          s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata, s_prdata;
  logic [SW-1:0] s_pwstrb;
  logic          timeout_pulse;

  apb_arbiter #(
    .P_ADDR_W(AW),
    .P_DATA_W(DW),
    .P_STRB_W(SW),
    .TIMEOUT (TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .timeout_pulse(timeout_pulse)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Model state: per-master outstanding request, and who was served last.
  bit          pend [2];
  bit          rw   [2];
  logic [31:0] ra   [2];
  logic [31:0] rd   [2];
  logic [3:0]  rs   [2];
  int          last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_masters();
    m0_psel = pend[0]; m0_penable = 1'b0; m0_pwrite = rw[0];
    m0_paddr = ra[0];  m0_pwdata = rd[0]; m0_pwstrb = rs[0];
    m1_psel = pend[1]; m1_penable = 1'b0; m1_pwrite = rw[1];
    m1_paddr = ra[1];  m1_pwdata = rd[1]; m1_pwstrb = rs[1];
  endtask

  task automatic new_req(input int m, input logic [31:0] a, input bit w,
                         input logic [31:0] d, input logic [3:0] s);
    pend[m] = 1'b1; ra[m] = a; rw[m] = w; rd[m] = d; rs[m] = s;
  endtask

  task automatic reset_dut();
    presetn = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_masters();
    s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = '0;
    tick();
    tick();
    presetn = 1'b1;
    last = 1;
  endtask

  // Called in an IDLE cycle with at least one request pending; returns in the next IDLE.
  task automatic do_xfer(input int waits, input bit serr, input logic [31:0] rdat);
    int          g;
    int          nacc;
    bit          timed;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    bit          ew;
    g    = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
    last = g;
    ea = ra[g]; ed = rd[g]; es = rs[g]; ew = rw[g];
    timed = (waits >= TO);
    nacc  = timed ? TO : waits + 1;
    drive_masters();
    s_pready = 1'b0;
    tick();
    chk("setup_psel",    s_psel,    1);
    chk("setup_penable", s_penable, 0);
    chk("setup_paddr",   s_paddr,   ea);
    chk("setup_pwrite",  s_pwrite,  ew);
    chk("setup_pwdata",  s_pwdata,  ed);
    chk("setup_pwstrb",  s_pwstrb,  es);
    // Upstream changes after sampling must not reach the downstream bus.
    ra[g] = $urandom; rd[g] = $urandom; rs[g] = 4'($urandom);
    drive_masters();
    if (g == 0) m0_penable = 1'b1; else m1_penable = 1'b1;
    for (int k = 0; k < nacc; k++) begin
      tick();
      chk("acc_psel",    s_psel,    1);
      chk("acc_penable", s_penable, 1);
      chk("acc_paddr",   s_paddr,   ea);
      chk("acc_pwdata",  s_pwdata,  ed);
      chk("acc_pwstrb",  s_pwstrb,  es);
      chk("acc_m0_pready", m0_pready, 0);
      chk("acc_m1_pready", m1_pready, 0);
      chk("acc_tpulse",  timeout_pulse, 0);
      s_pready  = (k == waits);
      s_prdata  = (k == waits) ? rdat : $urandom;
      s_pslverr = (k == waits) ? serr : 1'($urandom_range(0, 1));
    end
    tick();
    s_pready = 1'b0;
    chk("done_psel",    s_psel,    0);
    chk("done_penable", s_penable, 0);
    chk("done_tpulse",  timeout_pulse, timed);
    if (g == 0) begin
      chk("done_m0_pready",  m0_pready,  1);
      chk("done_m0_pslverr", m0_pslverr, timed ? 1'b1 : serr);
      chk("done_m0_prdata",  m0_prdata,  timed ? 32'h0 : rdat);
      chk("done_m1_pready",  m1_pready,  0);
      chk("done_m1_pslverr", m1_pslverr, 0);
    end else begin
      chk("done_m1_pready",  m1_pready,  1);
      chk("done_m1_pslverr", m1_pslverr, timed ? 1'b1 : serr);
      chk("done_m1_prdata",  m1_prdata,  timed ? 32'h0 : rdat);
      chk("done_m0_pready",  m0_pready,  0);
      chk("done_m0_pslverr", m0_pslverr, 0);
    end
    tick();
    pend[g] = 1'b0;
    drive_masters();
    chk("idle_m0_pready", m0_pready, 0);
    chk("idle_m1_pready", m1_pready, 0);
    chk("idle_tpulse",    timeout_pulse, 0);
    chk("idle_psel",      s_psel, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rw[0] = 0; rw[1] = 0; ra[0] = '0; ra[1] = '0;
    rd[0] = '0; rd[1] = '0; rs[0] = '0; rs[1] = '0;
    reset_dut();
    presetn = 1'b0;
    #1;
    chk("rst_s_psel",    s_psel,    0);
    chk("rst_s_penable", s_penable, 0);
    chk("rst_s_pwrite",  s_pwrite,  0);
    chk("rst_s_paddr",   s_paddr,   0);
    chk("rst_s_pwdata",  s_pwdata,  0);
    chk("rst_s_pwstrb",  s_pwstrb,  0);
    chk("rst_m0_pready", m0_pready, 0);
    chk("rst_m1_pready", m1_pready, 0);
    chk("rst_m0_pslverr", m0_pslverr, 0);
    chk("rst_m1_pslverr", m1_pslverr, 0);
    chk("rst_prdata",    m0_prdata, 0);
    chk("rst_tpulse",    timeout_pulse, 0);
    reset_dut();

    // Single zero-wait read from m0.
    new_req(0, 32'h0000_0100, 1'b0, 32'h0, 4'h0);
    do_xfer(0, 1'b0, 32'hDEAD_BEEF);

    // Simultaneous writes from reset, then two more contended rounds.
    reset_dut();
    new_req(0, 32'h10, 1'b1, 32'h1111_0000, 4'hF);
    new_req(1, 32'h20, 1'b1, 32'h2222_0000, 4'hF);
    do_xfer(0, 1'b0, 32'h0);
    do_xfer(0, 1'b0, 32'h0);
    for (int r = 0; r < 2; r++) begin
      new_req(0, 32'h30 + 32'(r), 1'b1, $urandom, 4'hF);
      new_req(1, 32'h40 + 32'(r), 1'b1, $urandom, 4'hF);
      do_xfer(0, 1'b0, 32'h0);
      do_xfer(1, 1'b0, 32'h0);
    end

    // m1 write with 5 wait states.
    new_req(1, 32'h0000_0200, 1'b1, 32'h1234_5678, 4'h3);
    do_xfer(5, 1'b0, 32'h0);

    // Timeout, boundary just inside the limit, and downstream error.
    new_req(0, 32'h0000_0300, 1'b0, 32'h0, 4'h0);
    do_xfer(100, 1'b0, 32'hFFFF_FFFF);
    new_req(0, 32'h0000_0304, 1'b0, 32'h0, 4'h0);
    do_xfer(TO - 1, 1'b0, 32'h0BAD_F00D);
    new_req(0, 32'h0000_0308, 1'b0, 32'h0, 4'h0);
    do_xfer(TO, 1'b0, 32'h0BAD_F00D);
    new_req(1, 32'h0000_0400, 1'b0, 32'h0, 4'h0);
    do_xfer(2, 1'b1, 32'hA5A5_A5A5);

    // Reset during ACCESS with wait states outstanding; m1 stays pending.
    reset_dut();
    new_req(0, 32'h0000_0500, 1'b0, 32'h0, 4'h0);
    new_req(1, 32'h0000_0600, 1'b1, 32'hCAFE_0001, 4'h5);
    drive_masters();
    tick();
    tick();
    tick();
    chk("mid_pre_penable", s_penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("mid_rst_psel",      s_psel,    0);
    chk("mid_rst_penable",   s_penable, 0);
    chk("mid_rst_m0_pready", m0_pready, 0);
    chk("mid_rst_m1_pready", m1_pready, 0);
    pend[0] = 1'b0;
    drive_masters();
    tick();
    presetn = 1'b1;
    last = 1;
    chk("post_rst_m0_pready", m0_pready, 0);
    do_xfer(1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 9) < 6)
          new_req(m, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      if (!pend[0] && !pend[1]) begin
        drive_masters();
        tick();
        chk("rand_idle_psel", s_psel, 0);
      end else begin
        do_xfer(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-master APB arbiter that shares the single peripheral APB path (into the async FIFO / demux) between two requesters, e.g. the core MMIO APB port and a boot/DMA loader.
- Acts as an APB slave to each upstream master and as the APB master on the shared downstream bus.
- Round-robin grant; each transfer is held for its full duration.
- Bounded pready wait: a transfer that times out completes with pslverr.

Parameters:
P_ADDR_W, 32, APB address width
P_DATA_W, 32, APB data width
P_STRB_W, 4, APB write-strobe width (P_DATA_W/8)
TIMEOUT, 255, max downstream ACCESS cycles before abort; 0 disables timeout

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
m0_psel / m1_psel  in  1  upstream master request
m0_penable / m1_penable  in  1  upstream access phase (ignored for arbitration)
m0_pwrite / m1_pwrite  in  1  upstream direction
m0_paddr / m1_paddr  in  P_ADDR_W  upstream address
m0_pwdata / m1_pwdata  in  P_DATA_W  upstream write data
m0_pwstrb / m1_pwstrb  in  P_STRB_W  upstream write strobes
m0_pready / m1_pready  out  1  upstream completion
m0_prdata / m1_prdata  out  P_DATA_W  upstream read data
m0_pslverr / m1_pslverr  out  1  upstream error
s_psel  out  1  downstream select
s_penable  out  1  downstream enable
s_pwrite  out  1  downstream direction
s_paddr  out  P_ADDR_W  downstream address
s_pwdata  out  P_DATA_W  downstream write data
s_pwstrb  out  P_STRB_W  downstream strobes
s_pready  in  1  downstream ready
s_prdata  in  P_DATA_W  downstream read data
s_pslverr  in  1  downstream error
timeout_pulse  out  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Clocking and reset: one clock, pclk; reset is asynchronous and active-low, presetn.
- Reset values:
  - FSM = IDLE; grant = 0; last_grant = 1, so m0 wins the first tie.
  - All s_* outputs = 0; all m*_pready/pslverr = 0; rdata_q = 0; timeout counter = 0; timeout_pulse = 0.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - A request is mX_psel=1.
  - Only one requests: grant it.
  - Both request: grant the master != last_grant.
  - On grant: register pwrite/paddr/pwdata/pwstrb of the winner into the s_* outputs, set last_grant=winner, go SETUP.
  - No request: stay in IDLE, s_psel=0.
- SETUP: s_psel=1, s_penable=0; next state ACCESS unconditionally.
- ACCESS:
  - s_psel=1, s_penable=1.
  - If s_pready=1: capture s_prdata into rdata_q and s_pslverr into err_q, go DONE.
  - Else increment the counter.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with s_pready=0: rdata_q=0, err_q=1, timeout_pulse=1 for one cycle, go DONE.
  - s_pready takes priority over timeout in the same cycle.
- DONE:
  - s_psel=0, s_penable=0.
  - Granted master sees mX_pready=1 and mX_pslverr=err_q for exactly one cycle; then IDLE and the counter clears.
  - Non-granted master's pready/pslverr stay 0 at all times.
- Read data: mX_prdata = rdata_q for both masters. It is valid only while that master's pready=1.
- Upstream stability: upstream address/data are sampled only in IDLE. An upstream master holds psel (and raises penable) while its pready=0, per APB. Changes after sampling are ignored until the next grant.
- Latency: request seen in IDLE cycle N; s_psel at N+1; s_penable at N+2; with zero-wait slave, mX_pready at N+3. Minimum 4 cycles per transfer.
- Back-to-back: a master re-asserting psel immediately after its DONE is re-arbitrated in the following IDLE. Under contention, grants alternate m0,m1,m0,…
- Downstream slverr: a downstream pslverr is passed through as err_q with s_prdata captured unchanged.
- Reset mid-transfer: FSM returns to IDLE immediately and s_psel/s_penable drop. No pready is issued to the interrupted master.

Test Plan:
- Single m0 read, slave returns 0xDEADBEEF with 0 wait states -> s_psel at +1 and s_penable at +2; m0_pready=1 at +3 with m0_prdata=0xDEADBEEF; m1_pready stays 0.
- m0 and m1 request writes in the same cycle (addr 0x10 and 0x20) from reset -> downstream sees 0x10 first, then 0x20. Four more simultaneous requests -> strict alternation m0,m1,m0,m1.
- m1 write pwdata=0x12345678, pwstrb=0x3, slave inserts 5 wait states -> s_pwdata/s_pwstrb stable through ACCESS; m1_pready exactly one cycle after s_pready.
- TIMEOUT=8, slave never asserts pready -> after 8 ACCESS cycles: timeout_pulse=1 (one cycle), m0_pslverr=1, m0_prdata=0, s_psel=0; next request is serviced normally.
- Slave returns s_pslverr=1 with s_prdata=0xA5A5A5A5 -> granted master sees pslverr=1 and prdata=0xA5A5A5A5; no timeout_pulse.
- presetn pulsed low during ACCESS with 3 wait states pending -> s_psel/s_penable/mX_pready=0 immediately; after release, a pending m1 request is granted from IDLE.
